// File: rtl/sig_gen_pkg.sv
// Shared constants and helpers for the multi-channel test-signal generator.
package sig_gen_pkg;

  localparam int DEF_CNT_W  = 21;
  localparam int DEF_PERIOD = 16000;  // 3125 Hz at 50 MHz
  localparam int DEF_HIGH   = 8000;   // 50% duty
  localparam int MIN_PERIOD = 2;

  // Periods below MIN_PERIOD would make the wrap compare degenerate.
  function automatic logic [31:0] clamp_period(input logic [31:0] p);
    return (p < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : p;
  endfunction

endpackage

// File: rtl/sig_gen_multi_if.sv
// Configuration write port of the signal generator.
// Handshake: a write transfers on a sysclk edge where cfg_valid && cfg_ready;
// the master holds cfg_ch/cfg_period/cfg_high stable while cfg_valid is high,
// and cfg_ready is a combinational function of cfg_ch only.
interface sig_gen_multi_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 21
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_high;

  modport master (output cfg_valid, cfg_ch, cfg_period, cfg_high, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_period, cfg_high, output cfg_ready);
endinterface

// File: rtl/sig_gen_chan.sv
// One generator channel: period counter, active/shadow config, pending flag
// and registered waveform/tick outputs.
module sig_gen_chan
  import sig_gen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int DEF_P = DEF_PERIOD,
  parameter int DEF_H = DEF_HIGH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_period_i,
  input  logic [CNT_W-1:0] wr_high_i,
  output logic             ready_o,
  output logic             sig_o,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] p_q, p_d, h_q, h_d, ps_q, ps_d, hs_q, hs_d, cnt_q, cnt_d;
  logic             pend_q, pend_d, sig_q, sig_d, tick_q, tick_d;
  logic             wrap;
  logic [CNT_W-1:0] cnt_nxt, h_use;

  assign ready_o = ~pend_q;
  assign sig_o   = sig_q;
  assign tick_o  = tick_q;

  // Next-state: capture writes into the shadow, swap on the period boundary.
  always_comb begin
    p_d     = p_q;
    h_d     = h_q;
    ps_d    = ps_q;
    hs_d    = hs_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    sig_d   = 1'b0;
    tick_d  = 1'b0;
    cnt_nxt = '0;
    h_use   = h_q;
    wrap    = (cnt_q == p_q - ONE);

    // A write is only accepted while nothing is pending, so it never
    // coincides with the swap below.
    if (wr_i) begin
      ps_d   = CNT_W'(clamp_period(32'(wr_period_i)));
      hs_d   = wr_high_i;
      pend_d = 1'b1;
    end

    if (en_i) begin
      cnt_nxt = wrap ? '0 : cnt_q + ONE;
      if (wrap && pend_q) begin
        p_d    = ps_q;
        h_d    = hs_q;
        pend_d = 1'b0;
        h_use  = hs_q;
      end
      cnt_d  = cnt_nxt;
      sig_d  = (cnt_nxt < h_use);
      tick_d = (cnt_nxt == '0);
    end else if (wrap && pend_q) begin
      // Idle channel parked at P-1: take the new config straight away.
      p_d    = ps_q;
      h_d    = hs_q;
      pend_d = 1'b0;
      cnt_d  = ps_q - ONE;
    end else begin
      cnt_d = p_q - ONE;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q    <= CNT_W'(DEF_P);
      h_q    <= CNT_W'(DEF_H);
      ps_q   <= CNT_W'(DEF_P);
      hs_q   <= CNT_W'(DEF_H);
      pend_q <= 1'b0;
      cnt_q  <= CNT_W'(DEF_P - 1);
      sig_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      h_q    <= h_d;
      ps_q   <= ps_d;
      hs_q   <= hs_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      sig_q  <= sig_d;
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/sig_gen_multi.sv
// Multi-channel square/PWM test-signal generator with a shared config port.
module sig_gen_multi #(
  parameter int NCH        = 4,
  parameter int CNT_W      = sig_gen_pkg::DEF_CNT_W,
  parameter int DEF_PERIOD = sig_gen_pkg::DEF_PERIOD,
  parameter int DEF_HIGH   = sig_gen_pkg::DEF_HIGH
) (
  input  logic           sysclk,
  input  logic           resetb,
  input  logic [NCH-1:0] en,
  sig_gen_multi_if.slave cfg,
  output logic [NCH-1:0] sig_out,
  output logic [NCH-1:0] period_tick
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int NSEL = 1 << CH_W;

  logic [NCH-1:0]  wr_vec;
  logic [NCH-1:0]  rdy_vec;
  logic [NSEL-1:0] rdy_ext;
  logic            accept;

  // Unpopulated channel codes always read as ready so writes to them drain.
  always_comb begin
    rdy_ext          = '1;
    rdy_ext[NCH-1:0] = rdy_vec;
  end

  assign cfg.cfg_ready = rdy_ext[cfg.cfg_ch];
  assign accept        = cfg.cfg_valid & cfg.cfg_ready;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign wr_vec[gi] = accept && (cfg.cfg_ch == CH_W'(gi));

    sig_gen_chan #(
      .CNT_W (CNT_W),
      .DEF_P (DEF_PERIOD),
      .DEF_H (DEF_HIGH)
    ) u_chan (
      .clk         (sysclk),
      .rst_n       (resetb),
      .en_i        (en[gi]),
      .wr_i        (wr_vec[gi]),
      .wr_period_i (cfg.cfg_period),
      .wr_high_i   (cfg.cfg_high),
      .ready_o     (rdy_vec[gi]),
      .sig_o       (sig_out[gi]),
      .tick_o      (period_tick[gi])
    );
  end

endmodule

// File: tb/tb_sig_gen_multi.sv
// Directed bench for sig_gen_multi (5 channels so an out-of-range select exists).
module tb_sig_gen_multi;

  localparam int NCH   = 5;
  localparam int CH_W  = 3;
  localparam int CNT_W = 21;

  logic           sysclk;
  logic           resetb;
  logic [NCH-1:0] en;
  logic [NCH-1:0] sig_out;
  logic [NCH-1:0] period_tick;

  int checks = 0;
  int errors = 0;

  sig_gen_multi_if #(.CH_W(CH_W), .CNT_W(CNT_W)) cfg_if ();

  sig_gen_multi #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .sysclk      (sysclk),
    .resetb      (resetb),
    .en          (en),
    .cfg         (cfg_if.slave),
    .sig_out     (sig_out),
    .period_tick (period_tick)
  );

  // Clock / reset
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance n edges, landing 1 ns after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic cfg_write(input int ch, input int p, input int h);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_ch     = CH_W'(ch);
    cfg_if.cfg_period = CNT_W'(p);
    cfg_if.cfg_high   = CNT_W'(h);
    #1;
    check("wr_ready", 32'(cfg_if.cfg_ready), 32'd1);
    @(posedge sysclk);
    #1;
    cfg_if.cfg_valid = 1'b0;
  endtask

  // Enable ch, expect n cycles of period p / high h starting at cnt 0, then disable.
  task automatic run_check(input int ch, input int p, input int h, input int n);
    en[ch] = 1'b1;
    for (int k = 0; k < n; k++) begin
      step(1);
      check("run_sig", 32'(sig_out[ch]), 32'((k % p) < h));
      check("run_tick", 32'(period_tick[ch]), 32'((k % p) == 0));
    end
    en[ch] = 1'b0;
    step(1);
    check("off_sig", 32'(sig_out[ch]), 32'd0);
    check("off_tick", 32'(period_tick[ch]), 32'd0);
  endtask

  initial begin
    resetb            = 1'b0;
    en                = '0;
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_ch     = '0;
    cfg_if.cfg_period = '0;
    cfg_if.cfg_high   = '0;
    #12;
    check("rst_sig", 32'(sig_out), 32'd0);
    check("rst_tick", 32'(period_tick), 32'd0);
    check("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
    #10;
    resetb = 1'b1;

    // Defaults on ch0: 8000 high / 8000 low, tick every 16000
    en[0] = 1'b1;
    for (int k = 0; k < 16002; k++) begin
      step(1);
      check("def_sig", 32'(sig_out[0]), 32'((k % 16000) < 8000));
      check("def_tick", 32'(period_tick[0]), 32'((k % 16000) == 0));
    end
    en[0] = 1'b0;
    step(1);
    check("def_off", 32'(sig_out[0]), 32'd0);

    // ch1 P=4 H=1 written while idle
    cfg_write(1, 4, 1);
    step(1);
    check("ch1_ready", 32'(cfg_if.cfg_ready), 32'd1);
    run_check(1, 4, 1, 12);

    // ch2 mid-period update plus back-pressure
    cfg_write(2, 10, 5);
    step(1);
    en[2] = 1'b1;
    for (int k = 0; k < 22; k++) begin
      step(1);
      if (k < 10) begin
        check("upd_sig_old", 32'(sig_out[2]), 32'(k < 5));
        check("upd_tick_old", 32'(period_tick[2]), 32'(k == 0));
      end else begin
        check("upd_sig_new", 32'(sig_out[2]), 32'(((k - 10) % 6) < 2));
        check("upd_tick_new", 32'(period_tick[2]), 32'(((k - 10) % 6) == 0));
      end
      if (k == 3) begin
        cfg_if.cfg_valid = 1'b1;  cfg_if.cfg_ch = 3'd2;
        cfg_if.cfg_period = 21'd6; cfg_if.cfg_high = 21'd2;
        #1 check("upd_ready_in", 32'(cfg_if.cfg_ready), 32'd1);
      end else if (k == 4) begin
        cfg_if.cfg_period = 21'd8; cfg_if.cfg_high = 21'd8;
        #1 check("bp_ready_ch2", 32'(cfg_if.cfg_ready), 32'd0);
      end else if (k == 5) begin
        cfg_if.cfg_ch = 3'd3; cfg_if.cfg_period = 21'd3; cfg_if.cfg_high = 21'd1;
        #1 check("bp_ready_ch3", 32'(cfg_if.cfg_ready), 32'd1);
      end else if (k == 6) begin
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = 3'd2;
        #1 check("pend_ready", 32'(cfg_if.cfg_ready), 32'd0);
      end else if (k == 9) begin
        check("pend_ready_last", 32'(cfg_if.cfg_ready), 32'd0);
      end else if (k == 10) begin
        check("wrap_ready", 32'(cfg_if.cfg_ready), 32'd1);
      end
    end
    en[2] = 1'b0;
    step(1);
    check("ch2_off", 32'(sig_out[2]), 32'd0);
    cfg_if.cfg_ch = 3'd3;
    #1 check("ch3_ready", 32'(cfg_if.cfg_ready), 32'd1);
    run_check(3, 3, 1, 6);

    // Boundaries on ch4
    cfg_write(4, 0, 1);
    run_check(4, 2, 1, 6);
    cfg_write(4, 7, 7);
    run_check(4, 7, 7, 15);
    cfg_write(4, 5, 0);
    run_check(4, 5, 0, 11);

    // Out-of-range channel: accepted, nothing changes
    cfg_write(5, 3, 3);
    step(1);
    for (int ch = 0; ch < NCH; ch++) begin
      cfg_if.cfg_ch = CH_W'(ch);
      #1 check("oor_ready", 32'(cfg_if.cfg_ready), 32'd1);
    end
    run_check(4, 5, 0, 6);
    run_check(1, 4, 1, 4);

    // Drop enable mid-period and restart
    cfg_write(0, 10, 6);
    en[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(1);
      check("mid_sig", 32'(sig_out[0]), 32'(k < 6));
    end
    en[0] = 1'b0;
    step(1);
    check("drop_sig", 32'(sig_out[0]), 32'd0);
    check("drop_tick", 32'(period_tick[0]), 32'd0);
    step(2);
    check("drop_hold", 32'(sig_out[0]), 32'd0);
    run_check(0, 10, 6, 12);

    // Asynchronous reset mid-run discards a pending write
    en[0] = 1'b1;
    en[1] = 1'b1;
    step(3);
    cfg_write(2, 3, 3);
    #2 resetb = 1'b0;
    #1;
    check("arst_sig", 32'(sig_out), 32'd0);
    check("arst_tick", 32'(period_tick), 32'd0);
    cfg_if.cfg_ch = 3'd2;
    #1 check("arst_ready", 32'(cfg_if.cfg_ready), 32'd1);
    en = 5'b00101;
    #2 resetb = 1'b1;
    for (int k = 0; k < 8002; k++) begin
      step(1);
      check("post_rst_sig0", 32'(sig_out[0]), 32'(k < 8000));
      check("post_rst_tick0", 32'(period_tick[0]), 32'(k == 0));
      check("post_rst_sig2", 32'(sig_out[2]), 32'(k < 8000));
    end
    en = '0;
    step(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sig_gen_multi.md
Name: sig_gen_multi

Overview:
Parametrised multi-channel test-signal generator; successor to the fixed 4-mode single-output frequency source.
Each channel produces a square/PWM wave with runtime-programmable period and high time, counted in sysclk cycles.
Configuration arrives over a valid/ready write port and is applied glitch-free on the channel's period boundary.
Drives the stimulus inputs of the frequency-meter and capture blocks on the board.

Parameters:
NCH, 4, number of independent output channels (1..16)
CNT_W, 21, width of the period/high counters; max period 2^CNT_W-1 cycles
DEF_PERIOD, 16000, reset period in cycles (3125 Hz at 50 MHz)
DEF_HIGH, 8000, reset high time in cycles (50% duty)
CH_W, $clog2(NCH) min 1, width of the channel select

Ports:
sysclk  in  1  50 MHz system clock
resetb  in  1  asynchronous active-low reset
en  in  NCH  per-channel run enable, level-sensitive
cfg_valid  in  1  configuration write request
cfg_ready  out  1  write accepted when cfg_valid & cfg_ready at a sysclk edge
cfg_ch  in  CH_W  target channel; values >= NCH are accepted and discarded
cfg_period  in  CNT_W  new period P in cycles
cfg_high  in  CNT_W  new high time H in cycles
sig_out  out  NCH  generated waveforms, registered
period_tick  out  NCH  one-cycle pulse on the first cycle of each period, registered

Behaviour:
- Reset (resetb low, asynchronous): every channel P=DEF_PERIOD, H=DEF_HIGH, cnt=P-1, pending=0. sig_out=0, period_tick=0, cfg_ready=1.
- Per channel: active registers P/H, shadow registers Ps/Hs, pending flag, counter cnt.
- Clamping at write time: P<2 stored as 2. H is stored as written.
- Enabled channel, every edge:
  - cnt_next = (cnt==P-1) ? 0 : cnt+1
  - sig_out <= (cnt_next < H)
  - period_tick <= (cnt_next==0)
- First edge with en high after disable: cnt_next=0, so sig_out=1 (if H>0) and period_tick=1. Latency from en sampled to output is one edge.
- H=0 gives constant low. H>=P gives constant high; period_tick still pulses every P cycles.
- Disabled channel: cnt held at P-1, sig_out<=0, period_tick<=0.
- Config handshake:
  - cfg_ready = !pending[cfg_ch] (combinational on cfg_ch); always 1 when cfg_ch >= NCH.
  - On an accepted write: Ps/Hs loaded and pending set.
- Applying pending config:
  - Enabled channel: on the edge where cnt==P-1 (wrap), P<=Ps, H<=Hs, pending cleared. sig_out for the new cnt_next=0 uses the new H. The current period always completes with the old values.
  - Disabled channel: applied on the edge after acceptance, with cnt<=Ps-1.
- Simultaneous accept and apply on the same channel cannot occur, because cfg_ready is low while pending.
- en falling mid-period: the next edge forces sig_out=0 and cnt=P-1. A pending config then applies on the following edge.
- Reset mid-operation discards pending writes and shadow values.
- Channels are fully independent. Writes to channel A never perturb the phase of channel B.
- No combinational path from any input to sig_out or period_tick.

Decomposition:
- Package sig_gen_pkg holds:
  - defaults DEF_PERIOD / DEF_HIGH
  - MIN_PERIOD=2
  - a function clamp_period(p) returning max(p, MIN_PERIOD)
- Sub-module sig_gen_chan implements one channel (counter, active/shadow registers, pending, output regs).
- The top instantiates NCH copies in a generate loop, then decodes cfg_ch to per-channel write strobes and muxes per-channel ready into cfg_ready.

Test Plan:
- Reset defaults: hold en=1 after reset -> sig_out[0] high 8000 cycles, low 8000 cycles; period_tick every 16000 cycles, first tick on the first enabled edge.
- Write ch1 P=4 H=1 while disabled, then en[1]=1 -> sig_out[1] pattern 1,0,0,0 repeating; period_tick[1] coincides with every 1.
- Mid-period update: ch2 running P=10 H=5; at cnt=3 write P=6 H=2.
  - cfg_ready drops next cycle.
  - Remaining 6 cycles keep the old waveform.
  - New period starts exactly at the wrap with 2 high / 4 low.
  - cfg_ready returns high on that edge.
- Back-pressure: second write to ch2 while pending -> cfg_ready=0, write not taken. Same-cycle write to ch3 -> cfg_ready=1, accepted.
- Boundaries:
  - P=0 stored as 2 -> output toggles 1,0.
  - H=0 -> constant 0.
  - H=P=7 -> constant 1, ticks every 7 cycles.
  - cfg_ch=NCH -> accepted, no channel changes.
- Disable/reset mid-run:
  - Drop en[0] at an arbitrary cnt -> sig_out[0]=0 the next edge.
  - Re-enable -> restarts at cnt 0 with a tick.
  - Assert resetb low asynchronously between edges -> all outputs 0 immediately and defaults restored.
